// File: rtl/i2c_codec_slave.sv
// I2C write-only responder shadowing the audio codec control registers.
// Optional feature: define I2C_SLV_SOFT_RESET_EN to make a write to register 0x0F clear the file.
`timescale 1ns/1ps
module i2c_codec_slave #(
   parameter logic [6:0] DEV_ADDR   = 7'h1A,
   parameter int         NUM_REGS   = 10,
   parameter int         FILTER_LEN = 3
) (
   input  logic                    CLOCK_50,
   input  logic                    iRST_N,
   input  logic                    I2C_SCLK,
   inout  wire                     I2C_SDAT,
   output logic [9*NUM_REGS-1:0]   REG_FLAT,
   output logic                    WR_STROBE,
   output logic [6:0]              WR_ADDR,
   output logic [8:0]              WR_DATA,
   output logic                    ACTIVE,
   output logic                    BUSY
);

   localparam int         CW            = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int         AW            = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [6:0] L_NREGS       = 7'(NUM_REGS);
   localparam logic [7:0] L_WR_ADDR     = {DEV_ADDR, 1'b0};
`ifdef I2C_SLV_SOFT_RESET_EN
   localparam logic [6:0] SOFT_RST_ADDR = 7'h0F;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_WAIT_STOP
   } state_t;

   // Index 0 carries SCL, index 1 carries SDA through the conditioning pipeline.
   logic [1:0]    w_raw;
   logic [1:0]    r_sync1, r_sync2, r_filt, r_filt_d;
   logic [CW-1:0] r_fcnt [2];

   logic w_scl, w_scl_d, w_sda, w_sda_d;
   logic w_scl_rise, w_scl_fall, w_start, w_stop;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_bit_cnt, w_cnt_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic       r_sda_oe, w_oe_nxt;
   logic       r_busy, w_busy_nxt;
   logic [6:0] r_addr, w_addr_nxt;
   logic       r_d8, w_d8_nxt;
   logic       w_commit;
   logic [7:0] w_byte;
   logic [8:0] w_cmt_data;

   logic [8:0] r_regs [NUM_REGS];
   logic       r_wr_strobe;
   logic [6:0] r_wr_addr;
   logic [8:0] r_wr_data;

   assign w_raw = {I2C_SDAT, I2C_SCLK};

   // Filters load with 1 so an idle bus produces no edges when reset lifts.
   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         r_sync1  <= '1;
         r_sync2  <= '1;
         r_filt   <= '1;
         r_filt_d <= '1;
         for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register sample pre-edge values.
         r_sync1  <= w_raw;
         r_sync2  <= r_sync1;
         r_filt_d <= r_filt;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_fcnt[i] <= '0;
            end else if (r_fcnt[i] == CW'(FILTER_LEN - 1)) begin
               r_filt[i] <= r_sync2[i];
               r_fcnt[i] <= '0;
            end else begin
               r_fcnt[i] <= r_fcnt[i] + CW'(1);
            end
         end
      end
   end

   assign w_scl      = r_filt[0];
   assign w_scl_d    = r_filt_d[0];
   assign w_sda      = r_filt[1];
   assign w_sda_d    = r_filt_d[1];
   assign w_scl_rise = w_scl & ~w_scl_d;
   assign w_scl_fall = ~w_scl & w_scl_d;
   assign w_start    = w_scl & w_scl_d & w_sda_d & ~w_sda;
   assign w_stop     = w_scl & w_scl_d & ~w_sda_d & w_sda;

   assign w_byte     = {r_shift[6:0], w_sda};
   assign w_cmt_data = {r_d8, w_byte};

   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_sda_oe  <= 1'b0;
         r_busy    <= 1'b0;
         r_addr    <= '0;
         r_d8      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_sda_oe  <= w_oe_nxt;
         r_busy    <= w_busy_nxt;
         r_addr    <= w_addr_nxt;
         r_d8      <= w_d8_nxt;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_oe_nxt    = r_sda_oe;
      w_busy_nxt  = r_busy;
      w_addr_nxt  = r_addr;
      w_d8_nxt    = r_d8;
      w_commit    = 1'b0;
      if (w_stop) begin
         w_state_nxt = S_IDLE;
         w_oe_nxt    = 1'b0;
         w_busy_nxt  = 1'b0;
         w_cnt_nxt   = '0;
      end else if (w_start) begin
         w_state_nxt = S_ADDR;
         w_oe_nxt    = 1'b0;
         w_busy_nxt  = 1'b1;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            S_ADDR, S_BYTE1, S_BYTE2: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_byte;
                  w_cnt_nxt   = r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd7) begin
                     w_cnt_nxt = '0;
                     case (r_state)
                        S_ADDR:  w_state_nxt = S_ADDR_ACK;
                        S_BYTE1: begin
                           w_addr_nxt  = w_byte[7:1];
                           w_d8_nxt    = w_byte[0];
                           w_state_nxt = S_ACK1;
                        end
                        default: begin
                           w_commit    = 1'b1;
                           w_state_nxt = S_ACK2;
                        end
                     endcase
                  end
               end
            end
            // First SCL fall after bit 8 starts the ACK slot, the second ends it.
            S_ADDR_ACK, S_ACK1, S_ACK2: begin
               if (w_scl_fall) begin
                  if (r_sda_oe) begin
                     w_oe_nxt = 1'b0;
                     if (r_state == S_ADDR_ACK)  w_state_nxt = S_BYTE1;
                     else if (r_state == S_ACK1) w_state_nxt = S_BYTE2;
                     else                        w_state_nxt = S_WAIT_STOP;
                  end else if (r_state == S_ADDR_ACK && r_shift != L_WR_ADDR) begin
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_oe_nxt = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the register file is reset because its contents are visible on REG_FLAT.
   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
      end else begin
         r_wr_strobe <= 1'b0;
         if (w_commit) begin
`ifdef I2C_SLV_SOFT_RESET_EN
            if (r_addr == SOFT_RST_ADDR) begin
               for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
               r_wr_strobe <= 1'b1;
               r_wr_addr   <= r_addr;
               r_wr_data   <= w_cmt_data;
            end else
`endif
            if (r_addr < L_NREGS) begin
               r_regs[r_addr[AW-1:0]] <= w_cmt_data;
               r_wr_strobe            <= 1'b1;
               r_wr_addr              <= r_addr;
               r_wr_data              <= w_cmt_data;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign REG_FLAT[9*g +: 9] = r_regs[g];
   end

   if (NUM_REGS > 9) begin : g_active
      assign ACTIVE = r_regs[9][0];
   end else begin : g_no_active
      assign ACTIVE = 1'b0;
   end

   assign I2C_SDAT  = r_sda_oe ? 1'b0 : 1'bz;
   assign WR_STROBE = r_wr_strobe;
   assign WR_ADDR   = r_wr_addr;
   assign WR_DATA   = r_wr_data;
   assign BUSY      = r_busy;

endmodule
